// File: rtl/pkt_rr_mux_if.sv
// pkt_rr_mux_if: FAST packet bus bundle for the N-input merger.
// Per-channel input side plus the single merged output side.
interface pkt_rr_mux_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]     in_data_wr;
  logic [NUM_CH*134-1:0] in_data;
  logic [NUM_CH-1:0]     in_data_valid;
  logic [NUM_CH-1:0]     in_data_valid_wr;
  logic [NUM_CH-1:0]     in_data_alf;
  logic                  out_data_wr;
  logic [133:0]          out_data;
  logic                  out_data_valid;
  logic                  out_data_valid_wr;
  logic                  out_data_alf;

  modport slave (
    input  in_data_wr, in_data, in_data_valid,
    input  in_data_valid_wr, out_data_alf,
    output in_data_alf, out_data_wr, out_data,
    output out_data_valid, out_data_valid_wr
  );

  modport master (
    output in_data_wr, in_data, in_data_valid,
    output in_data_valid_wr, out_data_alf,
    input  in_data_alf, out_data_wr, out_data,
    input  out_data_valid, out_data_valid_wr
  );
endinterface

// File: rtl/pkt_rr_mux.sv
// pkt_rr_mux: per-channel FIFOs, packet-atomic round-robin merge.
// Option macro PKT_MUX_CH0_PRIO_EN: channel 0 strict priority in IDLE.
module pkt_rr_mux #(
  parameter int NUM_CH     = 4,
  parameter int DATA_DEPTH = 256,
  parameter int VLD_DEPTH  = 16,
  parameter int ALF_MARGIN = 32,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pkt_rr_mux_if.slave             bus,
  output logic [NUM_CH*CNT_W-1:0] pkt_cnt,
  output logic [NUM_CH-1:0]       ovf_err
);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int VAW = $clog2(VLD_DEPTH);
  localparam int CHW = $clog2(NUM_CH);
  localparam logic [1:0] TYP_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE, GRANT, SEND
  } state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] gnt_q, gnt_d;
  logic [CHW-1:0] rr_q, rr_d;
  logic [CHW-1:0] win;
  logic           vflag_q, vflag_d;

  logic [NUM_CH-1:0] elig, vhead, d_empty;
  logic [NUM_CH-1:0] d_rd, v_rd, alf_v;
  logic [133:0]      dhead [NUM_CH];

  logic [133:0] word;
  logic         rd_fire, is_tail, cnt_inc;
  logic         out_wr_q, out_v_q, out_vwr_q;
  logic [133:0] out_data_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [133:0]     dmem [DATA_DEPTH];
    logic             vmem [VLD_DEPTH];
    logic [DAW:0]     dwp_q, drp_q, dcnt;
    logic [VAW:0]     vwp_q, vrp_q, vcnt;
    logic             d_wr, v_wr, d_alf, v_alf;
    logic             alf_q, ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic [133:0]     wdat;

    assign wdat  = bus.in_data[c*134 +: 134];
    assign dcnt  = dwp_q - drp_q;
    assign vcnt  = vwp_q - vrp_q;
    // a pop in the same cycle frees the slot before the push lands
    assign d_wr  = bus.in_data_wr[c] & (~dcnt[DAW] | d_rd[c]);
    assign v_wr  = bus.in_data_valid_wr[c] & (~vcnt[VAW] | v_rd[c]);
    assign d_alf = (DATA_DEPTH - int'(dcnt)) <= ALF_MARGIN;
    assign v_alf = (VLD_DEPTH - int'(vcnt)) <= 2;

    assign d_empty[c] = (dcnt == '0);
    assign elig[c]    = (vcnt != '0);
    assign dhead[c]   = dmem[drp_q[DAW-1:0]];
    assign vhead[c]   = vmem[vrp_q[VAW-1:0]];
    assign alf_v[c]   = alf_q;
    assign ovf_err[c] = ovf_q;
    assign pkt_cnt[c*CNT_W +: CNT_W] = cnt_q;

    // storage arrays, no reset needed
    always_ff @(posedge clk) begin
      if (d_wr) dmem[dwp_q[DAW-1:0]] <= wdat;
      if (v_wr) vmem[vwp_q[VAW-1:0]] <= bus.in_data_valid[c];
    end

    // pointers, almost-full, sticky overflow, packet counter
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dwp_q <= '0;
        drp_q <= '0;
        vwp_q <= '0;
        vrp_q <= '0;
        alf_q <= 1'b0;
        ovf_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        if (d_wr)    dwp_q <= dwp_q + 1'b1;
        if (d_rd[c]) drp_q <= drp_q + 1'b1;
        if (v_wr)    vwp_q <= vwp_q + 1'b1;
        if (v_rd[c]) vrp_q <= vrp_q + 1'b1;
        alf_q <= d_alf | v_alf;
        ovf_q <= ovf_q
               | (bus.in_data_wr[c] & ~d_wr)
               | (bus.in_data_valid_wr[c] & ~v_wr);
        if (cnt_inc && gnt_q == CHW'(c))
          cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // winner: first eligible channel after rr_q, wrapping
  always_comb begin
    win = rr_q;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (elig[(int'(rr_q) + i) % NUM_CH])
        win = CHW'((int'(rr_q) + i) % NUM_CH);
    end
`ifdef PKT_MUX_CH0_PRIO_EN
    if (elig[0]) win = '0;
`endif
  end

  assign word    = dhead[gnt_q];
  assign is_tail = (word[133:132] == TYP_TAIL);

  // FSM state and grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      vflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      vflag_q <= vflag_d;
    end
  end

  // FSM next state, FIFO pops
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    vflag_d = vflag_q;
    d_rd    = '0;
    v_rd    = '0;
    rd_fire = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|elig && !bus.out_data_alf) begin
          gnt_d   = win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        v_rd[gnt_q] = 1'b1;
        vflag_d     = vhead[gnt_q];
        state_d     = SEND;
      end
      SEND: begin
        if (!bus.out_data_alf && !d_empty[gnt_q]) begin
          d_rd[gnt_q] = 1'b1;
          rd_fire     = 1'b1;
          if (is_tail) begin
            cnt_inc = 1'b1;
            state_d = IDLE;
`ifdef PKT_MUX_CH0_PRIO_EN
            if (gnt_q != '0) rr_d = gnt_q;
`else
            rr_d = gnt_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_vwr_q  <= 1'b0;
      out_v_q    <= 1'b0;
    end else begin
      out_wr_q  <= rd_fire;
      if (rd_fire) out_data_q <= word;
      out_vwr_q <= rd_fire & is_tail;
      out_v_q   <= rd_fire & is_tail & vflag_q;
    end
  end

  assign bus.out_data_wr       = out_wr_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_data_valid_wr = out_vwr_q;
  assign bus.out_data_valid    = out_v_q;
  assign bus.in_data_alf       = alf_v;
endmodule

// File: tb/tb_pkt_rr_mux.sv
// tb_pkt_rr_mux: directed bench for pkt_rr_mux.
// Output words are logged with their cycle number for later checks.
module tb_pkt_rr_mux;
  localparam int NUM_CH = 4;
  localparam int DD     = 256;
  localparam int VD     = 16;
  localparam int AM     = 32;
  localparam int CW     = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH*CW-1:0] pkt_cnt;
  logic [NUM_CH-1:0]    ovf_err;

  pkt_rr_mux_if #(.NUM_CH(NUM_CH)) bus ();

  pkt_rr_mux #(
    .NUM_CH(NUM_CH), .DATA_DEPTH(DD), .VLD_DEPTH(VD),
    .ALF_MARGIN(AM), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .pkt_cnt(pkt_cnt), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [133:0] oq_d [$];
  bit           oq_vwr [$];
  bit           oq_v [$];
  int           oq_c [$];

  always @(negedge clk) begin
    if (bus.out_data_wr === 1'b1) begin
      oq_d.push_back(bus.out_data);
      oq_vwr.push_back(bus.out_data_valid_wr);
      oq_v.push_back(bus.out_data_valid);
      oq_c.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [133:0] mkw(input logic [1:0] typ,
                                       input int ch, input int idx);
    logic [133:0] w;
    w = '0;
    w[133:132] = typ;
    w[7:0]     = ch[7:0];
    w[31:16]   = idx[15:0];
    return w;
  endfunction

  task automatic clr();
    bus.in_data_wr       = '0;
    bus.in_data          = '0;
    bus.in_data_valid    = '0;
    bus.in_data_valid_wr = '0;
  endtask

  task automatic qclr();
    oq_d.delete();
    oq_vwr.delete();
    oq_v.delete();
    oq_c.delete();
  endtask

  task automatic put(input int ch, input logic [1:0] typ, input int idx,
                     input logic vwr, input logic vld);
    @(negedge clk);
    clr();
    bus.in_data_wr[ch] = 1'b1;
    bus.in_data[ch*134 +: 134] = mkw(typ, ch, idx);
    bus.in_data_valid_wr[ch] = vwr;
    bus.in_data_valid[ch] = vld;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    qclr();
  endtask

  task automatic test_reset();
    clr();
    bus.out_data_alf = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.out_data_wr !== 1'b0) begin
      n_bad++; $display("FAIL rst_out_wr: got %0b want 0", bus.out_data_wr);
    end
    n_cmp++;
    if (bus.out_data !== 134'd0) begin
      n_bad++; $display("FAIL rst_out_data: got %0h want 0", bus.out_data);
    end
    n_cmp++;
    if ({bus.out_data_valid, bus.out_data_valid_wr} !== 2'b00) begin
      n_bad++; $display("FAIL rst_out_valid: got %0b%0b want 00",
                        bus.out_data_valid, bus.out_data_valid_wr);
    end
    n_cmp++;
    if (bus.in_data_alf !== 4'h0) begin
      n_bad++; $display("FAIL rst_alf: got %0h want 0", bus.in_data_alf);
    end
    n_cmp++;
    if (pkt_cnt !== '0) begin
      n_bad++; $display("FAIL rst_cnt: got %0h want 0", pkt_cnt);
    end
    n_cmp++;
    if (ovf_err !== 4'h0) begin
      n_bad++; $display("FAIL rst_ovf: got %0h want 0", ovf_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    qclr();
  endtask

  task automatic test_single_packet();
    int t;
    logic [1:0] typ [4];
    typ[0] = 2'b01; typ[1] = 2'b11; typ[2] = 2'b11; typ[3] = 2'b10;
    qclr();
    for (int i = 0; i < 4; i++) put(2, typ[i], i, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    bus.in_data_valid_wr[2] = 1'b1;
    bus.in_data_valid[2] = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    clr();
    for (int i = 0; i < 40 && oq_d.size() < 4; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (oq_d.size() != 4) begin
      n_bad++; $display("FAIL single_len: got %0d want 4", oq_d.size());
    end
    for (int i = 0; i < 4 && i < oq_d.size(); i++) begin
      n_cmp++;
      if (oq_c[i] != t + 3 + i) begin
        n_bad++; $display("FAIL single_cyc%0d: got %0d want %0d",
                          i, oq_c[i], t + 3 + i);
      end
      n_cmp++;
      if (oq_d[i] !== mkw(typ[i], 2, i)) begin
        n_bad++; $display("FAIL single_word%0d: got %0h want %0h",
                          i, oq_d[i], mkw(typ[i], 2, i));
      end
      n_cmp++;
      if ({oq_vwr[i], oq_v[i]} !== {2{i == 3}}) begin
        n_bad++; $display("FAIL single_vld%0d: got %0b%0b want %0b%0b",
                          i, oq_vwr[i], oq_v[i], i == 3, i == 3);
      end
    end
    n_cmp++;
    if (pkt_cnt[2*CW +: CW] !== 32'd1) begin
      n_bad++; $display("FAIL single_cnt: got %0d want 1",
                        pkt_cnt[2*CW +: CW]);
    end
  endtask

  task automatic test_invalid_packet();
    qclr();
    put(3, 2'b01, 0, 1'b0, 1'b0);
    put(3, 2'b10, 1, 1'b1, 1'b0);
    @(negedge clk);
    clr();
    for (int i = 0; i < 40 && oq_d.size() < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (oq_d.size() != 2) begin
      n_bad++; $display("FAIL inv_len: got %0d want 2", oq_d.size());
    end else begin
      n_cmp++;
      if (oq_d[1] !== mkw(2'b10, 3, 1)) begin
        n_bad++; $display("FAIL inv_word: got %0h want %0h",
                          oq_d[1], mkw(2'b10, 3, 1));
      end
      n_cmp++;
      if ({oq_vwr[1], oq_v[1]} !== 2'b10) begin
        n_bad++; $display("FAIL inv_vld: got %0b%0b want 10",
                          oq_vwr[1], oq_v[1]);
      end
    end
    n_cmp++;
    if (pkt_cnt[3*CW +: CW] !== 32'd1) begin
      n_bad++; $display("FAIL inv_cnt: got %0d want 1",
                        pkt_cnt[3*CW +: CW]);
    end
  endtask

  task automatic test_fairness();
    int ech [12];
    int eix [12];
    int n;
    do_reset();
    n = 0;
`ifdef PKT_MUX_CH0_PRIO_EN
    for (int k = 0; k < 3; k++) begin
      ech[n] = 0; eix[n] = k; n++;
    end
    for (int r = 0; r < 3; r++)
      for (int c = 1; c < 4; c++) begin
        ech[n] = c; eix[n] = r; n++;
      end
`else
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 4; j++) begin
        ech[n] = (j + 1) % 4; eix[n] = r; n++;
      end
`endif
    @(negedge clk);
    bus.out_data_alf = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      clr();
      for (int c = 0; c < 4; c++) begin
        bus.in_data_wr[c] = 1'b1;
        bus.in_data[c*134 +: 134] = mkw(2'b10, c, k);
        bus.in_data_valid_wr[c] = 1'b1;
        bus.in_data_valid[c] = 1'b1;
      end
    end
    @(negedge clk);
    clr();
    @(negedge clk);
    bus.out_data_alf = 1'b0;
    for (int i = 0; i < 200 && oq_d.size() < 12; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (oq_d.size() != 12) begin
      n_bad++; $display("FAIL fair_len: got %0d want 12", oq_d.size());
    end
    for (int i = 0; i < 12 && i < oq_d.size(); i++) begin
      n_cmp++;
      if (oq_d[i] !== mkw(2'b10, ech[i], eix[i])) begin
        n_bad++; $display("FAIL fair_order%0d: got %0h want %0h",
                          i, oq_d[i], mkw(2'b10, ech[i], eix[i]));
      end
    end
    n_cmp++;
    if (pkt_cnt !== {4{32'd3}}) begin
      n_bad++; $display("FAIL fair_cnt: got %0h want %0h",
                        pkt_cnt, {4{32'd3}});
    end
  endtask

  task automatic test_back_pressure();
    int t;
    int eoff [9];
    logic [133:0] ew [9];
    eoff = '{3, 4, 5, 11, 12, 13, 14, 15, 18};
    for (int i = 0; i < 8; i++)
      ew[i] = mkw(i == 0 ? 2'b01 : (i == 7 ? 2'b10 : 2'b11), 0, i);
    ew[8] = mkw(2'b10, 1, 0);
    qclr();
    for (int i = 0; i < 8; i++) put(0, ew[i][133:132], i, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    bus.in_data_valid_wr[0] = 1'b1;
    bus.in_data_valid[0] = 1'b1;
    t = cyc + 1;
    put(1, 2'b10, 0, 1'b1, 1'b1);
    @(negedge clk);
    clr();
    while (cyc < t + 5) @(negedge clk);
    bus.out_data_alf = 1'b1;
    while (cyc < t + 10) @(negedge clk);
    bus.out_data_alf = 1'b0;
    for (int i = 0; i < 60 && oq_d.size() < 9; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (oq_d.size() != 9) begin
      n_bad++; $display("FAIL bp_len: got %0d want 9", oq_d.size());
    end
    for (int i = 0; i < 9 && i < oq_d.size(); i++) begin
      n_cmp++;
      if (oq_c[i] != t + eoff[i]) begin
        n_bad++; $display("FAIL bp_cyc%0d: got %0d want %0d",
                          i, oq_c[i], t + eoff[i]);
      end
      n_cmp++;
      if (oq_d[i] !== ew[i]) begin
        n_bad++; $display("FAIL bp_word%0d: got %0h want %0h",
                          i, oq_d[i], ew[i]);
      end
    end
  endtask

  task automatic test_flow_control();
    qclr();
    for (int i = 0; i < DD - AM - 1; i++)
      put(1, i == 0 ? 2'b01 : 2'b11, i, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.in_data_alf[1] !== 1'b0) begin
      n_bad++; $display("FAIL fc_alf_below: got %0b want 0",
                        bus.in_data_alf[1]);
    end
    put(1, 2'b11, DD - AM - 1, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.in_data_alf[1] !== 1'b1) begin
      n_bad++; $display("FAIL fc_alf_at: got %0b want 1",
                        bus.in_data_alf[1]);
    end
    for (int i = DD - AM; i < DD; i++)
      put(1, i == DD - 1 ? 2'b10 : 2'b11, i, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    n_cmp++;
    if (ovf_err[1] !== 1'b0) begin
      n_bad++; $display("FAIL fc_ovf_full: got %0b want 0", ovf_err[1]);
    end
    put(1, 2'b10, DD, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    n_cmp++;
    if (ovf_err[1] !== 1'b1) begin
      n_bad++; $display("FAIL fc_ovf_set: got %0b want 1", ovf_err[1]);
    end
    @(negedge clk);
    bus.in_data_valid_wr[1] = 1'b1;
    bus.in_data_valid[1] = 1'b1;
    @(negedge clk);
    clr();
    for (int i = 0; i < 800 && oq_d.size() < DD; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (oq_d.size() != DD) begin
      n_bad++; $display("FAIL fc_len: got %0d want %0d", oq_d.size(), DD);
    end else begin
      n_cmp++;
      if (oq_d[DD-1] !== mkw(2'b10, 1, DD - 1)) begin
        n_bad++; $display("FAIL fc_last: got %0h want %0h",
                          oq_d[DD-1], mkw(2'b10, 1, DD - 1));
      end
    end
    n_cmp++;
    if (ovf_err[1] !== 1'b1) begin
      n_bad++; $display("FAIL fc_ovf_sticky: got %0b want 1", ovf_err[1]);
    end
    n_cmp++;
    if (bus.in_data_alf[1] !== 1'b0) begin
      n_bad++; $display("FAIL fc_alf_drain: got %0b want 0",
                        bus.in_data_alf[1]);
    end
    n_cmp++;
    if (pkt_cnt[1*CW +: CW] !== 32'd5) begin
      n_bad++; $display("FAIL fc_cnt: got %0d want 5",
                        pkt_cnt[1*CW +: CW]);
    end
  endtask

  task automatic test_reset_mid_packet();
    int t;
    qclr();
    for (int i = 0; i < 8; i++)
      put(2, i == 0 ? 2'b01 : (i == 7 ? 2'b10 : 2'b11), i, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    bus.in_data_valid_wr[2] = 1'b1;
    bus.in_data_valid[2] = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    clr();
    while (cyc < t + 5) @(negedge clk);
    n_cmp++;
    if (bus.out_data_wr !== 1'b1) begin
      n_bad++; $display("FAIL mid_sending: got %0b want 1", bus.out_data_wr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_data_wr, bus.out_data_valid, bus.out_data_valid_wr}
        !== 3'b000) begin
      n_bad++; $display("FAIL mid_rst_ctl: got %0b%0b%0b want 000",
                        bus.out_data_wr, bus.out_data_valid,
                        bus.out_data_valid_wr);
    end
    n_cmp++;
    if (bus.out_data !== 134'd0) begin
      n_bad++; $display("FAIL mid_rst_data: got %0h want 0", bus.out_data);
    end
    n_cmp++;
    if ({pkt_cnt, ovf_err} !== '0) begin
      n_bad++; $display("FAIL mid_rst_cnt: got %0h/%0h want 0",
                        pkt_cnt, ovf_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    qclr();
    put(0, 2'b10, 9, 1'b1, 1'b1);
    t = cyc + 1;
    @(negedge clk);
    clr();
    for (int i = 0; i < 40 && oq_d.size() < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (oq_d.size() != 1) begin
      n_bad++; $display("FAIL post_len: got %0d want 1", oq_d.size());
    end else begin
      n_cmp++;
      if (oq_c[0] != t + 3) begin
        n_bad++; $display("FAIL post_cyc: got %0d want %0d", oq_c[0], t + 3);
      end
      n_cmp++;
      if ({oq_d[0], oq_vwr[0], oq_v[0]} !== {mkw(2'b10, 0, 9), 2'b11}) begin
        n_bad++; $display("FAIL post_word: got %0h want %0h",
                          {oq_d[0], oq_vwr[0], oq_v[0]},
                          {mkw(2'b10, 0, 9), 2'b11});
      end
    end
    n_cmp++;
    if (pkt_cnt[0 +: CW] !== 32'd1) begin
      n_bad++; $display("FAIL post_cnt: got %0d want 1", pkt_cnt[0 +: CW]);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_invalid_packet();
    test_fairness();
    test_back_pressure();
    test_flow_control();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
